// File: rtl/dense_layer_ctrl.sv
// dense_layer_ctrl: sequences one input vector through clear, accumulate, bias and output phases
module dense_layer_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int WIDTH      = 16,
    parameter int NUM_NODES  = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_layer_active,
    input  logic                  i_start,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_in_valid,
    output logic                  o_in_ready,
    output logic [DATA_WIDTH-1:0] o_node_data,
    output logic [ADDR_WIDTH-1:0] o_weight_addr,
    output logic                  o_acc_clear,
    output logic                  o_acc_en,
    output logic                  o_bias_en,
    output logic                  o_out_valid,
    input  logic                  i_out_ready,
    output logic                  o_busy,
    output logic                  o_done
);

    if (WIDTH < 1 || WIDTH > 1024) begin : g_bad_width
        $error("WIDTH must be within 1..1024");
    end
    if ((64'd1 << ADDR_WIDTH) < 64'(WIDTH)) begin : g_bad_addr
        $error("ADDR_WIDTH too small to index WIDTH weights");
    end
    if (NUM_NODES < 1) begin : g_bad_nodes
        $error("NUM_NODES must be at least 1");
    end

    typedef enum logic [2:0] {IDLE, CLEAR, ACCUM, BIAS, OUTPUT} state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(WIDTH - 1);

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_cnt, w_cnt;
    logic [DATA_WIDTH-1:0] r_node_data, w_node_data;
    logic [ADDR_WIDTH-1:0] r_weight_addr, w_weight_addr;
    logic                  r_in_ready, r_acc_clear, r_acc_en, r_bias_en, r_out_valid, r_busy, r_done;
    logic                  w_in_ready, w_acc_clear, w_acc_en, w_bias_en, w_out_valid, w_busy, w_done;
    logic                  w_abort, w_accept, w_last, w_take;

    assign w_abort  = (r_state != IDLE) && !i_layer_active;
    assign w_accept = (r_state == ACCUM) && r_in_ready && i_in_valid && !w_abort;
    assign w_last   = w_accept && (r_cnt == LAST);
    assign w_take   = (r_state == OUTPUT) && r_out_valid && i_out_ready && !w_abort;

    // next state and next values of every registered output
    always_comb begin
        w_next = r_state;
        if (w_abort) begin
            w_next = IDLE;
        end else begin
            case (r_state)
                IDLE:    w_next = (i_start && i_layer_active) ? CLEAR : IDLE;
                CLEAR:   w_next = ACCUM;
                ACCUM:   w_next = w_last ? BIAS : ACCUM;
                BIAS:    w_next = OUTPUT;
                OUTPUT:  w_next = w_take ? IDLE : OUTPUT;
                default: w_next = IDLE;
            endcase
        end
        w_in_ready    = (w_next == ACCUM);
        w_acc_clear   = (w_next == CLEAR);
        w_acc_en      = w_accept;
        w_bias_en     = (r_state == BIAS) && (w_next == OUTPUT);
        w_out_valid   = (r_state == OUTPUT) && (w_next == OUTPUT);
        w_busy        = (w_next != IDLE);
        w_done        = w_take;
        w_cnt         = (w_abort || r_state == CLEAR || w_last) ? '0 :
                        w_accept ? r_cnt + ADDR_WIDTH'(1) : r_cnt;
        w_node_data   = w_accept ? i_data_in : r_node_data;
        w_weight_addr = w_accept ? r_cnt : r_weight_addr;
    end

    // state register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_next;
    end

    // registered outputs and beat counter
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt         <= '0;
            r_node_data   <= '0;
            r_weight_addr <= '0;
            r_in_ready    <= 1'b0;
            r_acc_clear   <= 1'b0;
            r_acc_en      <= 1'b0;
            r_bias_en     <= 1'b0;
            r_out_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            r_cnt         <= w_cnt;
            r_node_data   <= w_node_data;
            r_weight_addr <= w_weight_addr;
            r_in_ready    <= w_in_ready;
            r_acc_clear   <= w_acc_clear;
            r_acc_en      <= w_acc_en;
            r_bias_en     <= w_bias_en;
            r_out_valid   <= w_out_valid;
            r_busy        <= w_busy;
            r_done        <= w_done;
        end
    end

    assign o_in_ready    = r_in_ready;
    assign o_node_data   = r_node_data;
    assign o_weight_addr = r_weight_addr;
    assign o_acc_clear   = r_acc_clear;
    assign o_acc_en      = r_acc_en;
    assign o_bias_en     = r_bias_en;
    assign o_out_valid   = r_out_valid;
    assign o_busy        = r_busy;
    assign o_done        = r_done;

endmodule

// File: tb/tb_dense_layer_ctrl.sv
// tb_dense_layer_ctrl: scoreboard bench for the dense layer sequencer (WIDTH=16 and WIDTH=1 builds)
module tb_dense_layer_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        a_act = 1'b0, a_start = 1'b0, a_in_valid = 1'b0, a_out_ready = 1'b0;
    logic [15:0] a_data_in = '0;
    logic        a_in_ready, a_acc_clear, a_acc_en, a_bias_en, a_out_valid, a_busy, a_done;
    logic [15:0] a_node_data;
    logic [3:0]  a_weight_addr;

    logic        b_act = 1'b0, b_start = 1'b0, b_in_valid = 1'b0, b_out_ready = 1'b0;
    logic [15:0] b_data_in = '0;
    logic        b_in_ready, b_acc_clear, b_acc_en, b_bias_en, b_out_valid, b_busy, b_done;
    logic [15:0] b_node_data;
    logic [0:0]  b_weight_addr;

    logic [26:0] a_outs, b_outs;
    assign a_outs = {a_in_ready, a_node_data, a_weight_addr, a_acc_clear, a_acc_en, a_bias_en, a_out_valid, a_busy, a_done};
    assign b_outs = {b_in_ready, b_node_data, 3'b000, b_weight_addr, b_acc_clear, b_acc_en, b_bias_en, b_out_valid, b_busy, b_done};

    int checks = 0;
    int errors = 0;
    int bias_cnt = 0;
    int done_cnt = 0;
    logic [19:0] exp_q[$];

    dense_layer_ctrl #(.DATA_WIDTH(16), .WIDTH(16), .NUM_NODES(16), .ADDR_WIDTH(4)) u_a (
        .i_clk(clk), .i_reset(rst), .i_layer_active(a_act), .i_start(a_start),
        .i_data_in(a_data_in), .i_in_valid(a_in_valid), .o_in_ready(a_in_ready),
        .o_node_data(a_node_data), .o_weight_addr(a_weight_addr), .o_acc_clear(a_acc_clear),
        .o_acc_en(a_acc_en), .o_bias_en(a_bias_en), .o_out_valid(a_out_valid),
        .i_out_ready(a_out_ready), .o_busy(a_busy), .o_done(a_done)
    );

    dense_layer_ctrl #(.DATA_WIDTH(16), .WIDTH(1), .NUM_NODES(16), .ADDR_WIDTH(1)) u_b (
        .i_clk(clk), .i_reset(rst), .i_layer_active(b_act), .i_start(b_start),
        .i_data_in(b_data_in), .i_in_valid(b_in_valid), .o_in_ready(b_in_ready),
        .o_node_data(b_node_data), .o_weight_addr(b_weight_addr), .o_acc_clear(b_acc_clear),
        .o_acc_en(b_acc_en), .o_bias_en(b_bias_en), .o_out_valid(b_out_valid),
        .i_out_ready(b_out_ready), .o_busy(b_busy), .o_done(b_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // monitor: every acc_en beat must match the next expected (addr, data) pair
    always @(negedge clk) begin
        logic [19:0] e;
        if (a_bias_en) bias_cnt++;
        if (a_done) done_cnt++;
        if (a_acc_en) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL acc_en_unexpected got addr %0h data %0h expected no beat at %0t", a_weight_addr, a_node_data, $time);
            end else begin
                e = exp_q.pop_front();
                chk("beat_addr", 32'(a_weight_addr), 32'(e[19:16]));
                chk("beat_data", 32'(a_node_data), 32'(e[15:0]));
                chk("beat_no_bias", 32'(a_bias_en), 32'd0);
            end
        end
    end

    // one vector on the WIDTH=16 build; gap toggles in_valid, stall delays out_ready,
    // abort_at drops layer_active after that many beats, rst_bias resets in BIAS
    task automatic vec(input bit gap, input int stall, input int abort_at, input bit rst_bias);
        int k;
        int n;
        bit acc;
        int b0;
        int d0;
        a_act = 1'b1;
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("acc_clear", 32'(a_acc_clear), 32'd1);
        chk("busy_run", 32'(a_busy), 32'd1);
        k = 0;
        n = 0;
        while (k < 16 && k != abort_at && n < 200) begin
            a_in_valid = gap ? !n[0] : 1'b1;
            a_data_in = 16'(k + 1);
            acc = a_in_ready && a_in_valid;
            if (acc) exp_q.push_back({4'(k), 16'(k + 1)});
            tick();
            n++;
            if (acc) k++;
        end
        a_in_valid = 1'b0;
        chk("beats_taken", 32'(k), 32'(abort_at >= 0 ? abort_at : 16));
        if (abort_at >= 0) begin
            a_act = 1'b0;
            b0 = bias_cnt;
            d0 = done_cnt;
            tick();
            chk("abort_in_ready", 32'(a_in_ready), 32'd0);
            chk("abort_busy", 32'(a_busy), 32'd0);
            chk("abort_acc_en", 32'(a_acc_en), 32'd0);
            repeat (6) tick();
            chk("abort_no_bias", 32'(bias_cnt), 32'(b0));
            chk("abort_no_done", 32'(done_cnt), 32'(d0));
            a_act = 1'b1;
            return;
        end
        chk("bias_in_ready", 32'(a_in_ready), 32'd0);
        chk("bias_early", 32'(a_bias_en), 32'd0);
        if (rst_bias) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
            chk("reset_in_bias_outs", 32'(a_outs), 32'd0);
            return;
        end
        tick();
        chk("bias_en_t2", 32'(a_bias_en), 32'd1);
        chk("out_valid_t2", 32'(a_out_valid), 32'd0);
        tick();
        chk("out_valid_t3", 32'(a_out_valid), 32'd1);
        chk("bias_en_t3", 32'(a_bias_en), 32'd0);
        for (int i = 0; i < stall; i++) begin
            a_start = (i == 3);
            tick();
            chk("stall_valid", 32'(a_out_valid), 32'd1);
            chk("stall_data", 32'(a_node_data), 32'd16);
            chk("stall_addr", 32'(a_weight_addr), 32'd15);
            chk("stall_clear", 32'(a_acc_clear), 32'd0);
        end
        a_start = 1'b0;
        a_out_ready = 1'b1;
        tick();
        a_out_ready = 1'b0;
        chk("done_pulse", 32'(a_done), 32'd1);
        chk("done_out_valid", 32'(a_out_valid), 32'd0);
        chk("done_busy", 32'(a_busy), 32'd0);
        tick();
        chk("done_one_cycle", 32'(a_done), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    // directed stimulus sequence
    initial begin
        repeat (3) tick();
        rst = 1'b0;
        repeat (5) tick();
        chk("reset_outs_a", 32'(a_outs), 32'd0);
        chk("reset_outs_b", 32'(b_outs), 32'd0);
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        tick();
        chk("inactive_start_busy", 32'(a_busy), 32'd0);
        chk("inactive_start_clear", 32'(a_acc_clear), 32'd0);
        vec(1'b0, 0, -1, 1'b0);
        vec(1'b1, 0, -1, 1'b0);
        vec(1'b0, 10, -1, 1'b0);
        vec(1'b0, 0, 8, 1'b0);
        vec(1'b0, 0, -1, 1'b0);
        vec(1'b0, 0, -1, 1'b1);
        b_act = 1'b1;
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        chk("b_acc_clear", 32'(b_acc_clear), 32'd1);
        b_in_valid = 1'b1;
        b_data_in = 16'h0055;
        tick();
        chk("b_in_ready", 32'(b_in_ready), 32'd1);
        tick();
        b_in_valid = 1'b0;
        chk("b_acc_en", 32'(b_acc_en), 32'd1);
        chk("b_addr", 32'(b_weight_addr), 32'd0);
        chk("b_data", 32'(b_node_data), 32'h55);
        chk("b_in_ready_drop", 32'(b_in_ready), 32'd0);
        tick();
        chk("b_bias_en", 32'(b_bias_en), 32'd1);
        chk("b_single_acc", 32'(b_acc_en), 32'd0);
        chk("b_out_valid_t2", 32'(b_out_valid), 32'd0);
        tick();
        chk("b_out_valid_t3", 32'(b_out_valid), 32'd1);
        b_out_ready = 1'b1;
        tick();
        b_out_ready = 1'b0;
        chk("b_done", 32'(b_done), 32'd1);
        chk("b_busy", 32'(b_busy), 32'd0);
        tick();
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
